// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver FSM states,
// the oversampling ratio and the tick positions derived from it.
package uart_pkg;

  // Number of stb_sample ticks per bit period.
  localparam int OVERSAMPLE = 16;

  // Tick counter width: holds 0..OVERSAMPLE-1.
  localparam int TICK_W = $clog2(OVERSAMPLE);

  // Tick index at which the start bit is re-checked (bit centre).
  localparam logic [TICK_W-1:0] START_CHECK_TICK = TICK_W'(OVERSAMPLE / 2 - 1);

  // Tick index of the last tick of a full bit period.
  localparam logic [TICK_W-1:0] BIT_END_TICK = TICK_W'(OVERSAMPLE - 1);

  // Receiver FSM states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  // Advance the tick counter by one; callers only do this below BIT_END_TICK,
  // so the counter never wraps inside a frame.
  function automatic logic [TICK_W-1:0] tick_inc(input logic [TICK_W-1:0] tick);
    tick_inc = tick + {{(TICK_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops come out of reset at RESET_VAL so an idle-high line does not
// look like a start bit right after reset.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage metastability filter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, LSB first, one stop bit.
// All state advances only on cycles where stb_sample is high; the received
// byte is held in a one-entry output buffer with a valid/ready handshake.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stb_sample,
  input  logic              serial_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  // Bit counter holds 0..DATA_W.
  localparam int BIT_CNT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

  logic                 rx_s;

  rx_state_t            state_r;
  rx_state_t            state_next_s;
  logic [TICK_W-1:0]    tick_cnt_r;
  logic [TICK_W-1:0]    tick_cnt_next_s;
  logic [BIT_CNT_W-1:0] bit_cnt_r;
  logic [BIT_CNT_W-1:0] bit_cnt_next_s;
  logic [DATA_W-1:0]    shift_r;
  logic [DATA_W-1:0]    shift_next_s;

  logic                 frame_ok_s;
  logic                 frame_bad_s;

  logic [DATA_W-1:0]    rx_data_r;
  logic                 rx_valid_r;
  logic                 frame_err_r;
  logic                 overrun_r;
  logic                 busy_r;

  uart_rx_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (serial_in),
    .q   (rx_s)
  );

  // FSM state, tick/bit counters and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      tick_cnt_r <= '0;
      bit_cnt_r  <= '0;
      shift_r    <= '0;
    end else begin
      state_r    <= state_next_s;
      tick_cnt_r <= tick_cnt_next_s;
      bit_cnt_r  <= bit_cnt_next_s;
      shift_r    <= shift_next_s;
    end
  end

  // Next-state logic; nothing moves except on a sample tick.
  always_comb begin
    state_next_s    = state_r;
    tick_cnt_next_s = tick_cnt_r;
    bit_cnt_next_s  = bit_cnt_r;
    shift_next_s    = shift_r;
    frame_ok_s      = 1'b0;
    frame_bad_s     = 1'b0;

    if (stb_sample) begin
      case (state_r)
        IDLE: begin
          if (!rx_s) begin
            state_next_s    = START;
            tick_cnt_next_s = '0;
          end else begin
            state_next_s    = IDLE;
          end
        end

        START: begin
          // Re-check the line at the start-bit centre to reject glitches.
          if (tick_cnt_r == START_CHECK_TICK) begin
            tick_cnt_next_s = '0;
            if (!rx_s) begin
              state_next_s   = DATA;
              bit_cnt_next_s = '0;
            end else begin
              state_next_s   = IDLE;
            end
          end else begin
            tick_cnt_next_s = tick_inc(tick_cnt_r);
          end
        end

        DATA: begin
          // One sample per bit period, shifted in from the top so the first
          // bit received ends up in bit 0.
          if (tick_cnt_r == BIT_END_TICK) begin
            tick_cnt_next_s = '0;
            shift_next_s    = {rx_s, shift_r[DATA_W-1:1]};
            bit_cnt_next_s  = bit_cnt_r + 1'b1;
            if (bit_cnt_r == LAST_BIT) begin
              state_next_s = STOP;
            end else begin
              state_next_s = DATA;
            end
          end else begin
            tick_cnt_next_s = tick_inc(tick_cnt_r);
          end
        end

        STOP: begin
          // Leaving at the stop-bit centre lets the next start edge be seen
          // on the very next low tick.
          if (tick_cnt_r == BIT_END_TICK) begin
            tick_cnt_next_s = '0;
            if (rx_s) begin
              state_next_s = IDLE;
              frame_ok_s   = 1'b1;
            end else begin
              state_next_s = BREAK;
              frame_bad_s  = 1'b1;
            end
          end else begin
            tick_cnt_next_s = tick_inc(tick_cnt_r);
          end
        end

        BREAK: begin
          // Wait for the line to return high before hunting for a start bit.
          if (rx_s) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = BREAK;
          end
        end

        default: begin
          state_next_s    = IDLE;
          tick_cnt_next_s = '0;
          bit_cnt_next_s  = '0;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Output buffer, handshake and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_r   <= '0;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      frame_err_r <= frame_bad_s;
      busy_r      <= (state_next_s != IDLE);
      if (frame_ok_s) begin
        if (!rx_valid_r || rx_ready) begin
          // Buffer is free, or being drained this very cycle.
          rx_data_r  <= shift_r;
          rx_valid_r <= 1'b1;
          overrun_r  <= 1'b0;
        end else begin
          // Buffer still held: keep the old byte, drop the new one.
          overrun_r  <= 1'b1;
        end
      end else begin
        overrun_r <= 1'b0;
        if (rx_valid_r && rx_ready) begin
          rx_valid_r <= 1'b0;
        end else begin
          rx_valid_r <= rx_valid_r;
        end
      end
    end
  end

  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: line waveforms are built per sample tick, and the
// expected completion/busy events are computed from frame arithmetic.
module tb_uart_rx;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              stb_sample;
  logic              serial_in;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              frame_err;
  logic              overrun;
  logic              busy;

  uart_rx #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .stb_sample (stb_sample),
    .serial_in  (serial_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Line value per tick, and events keyed by tick index.
  bit        line_q[$];
  int        cur_t = 0;
  int        done_kind[int];
  logic [7:0] done_data[int];
  bit        bon[int];
  bit        boff[int];

  // Events for the current clock cycle.
  logic       cur_done_ok, cur_done_err, cur_bon, cur_boff;
  logic [7:0] cur_data;

  int   cpt        = 4;
  int   ready_mode = 1;
  logic ready_val  = 1'b0;

  // Reference output state.
  logic       m_valid, m_ferr, m_ovr, m_busy;
  logic [7:0] m_data;

  int   cyc = 0;
  int   done_cyc = 0;
  int   rise_cyc = 0;
  logic prev_valid = 1'b0;
  int   ferr_seen = 0;
  int   ovr_seen = 0;
  bit   chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural reference: one-entry buffer fed by precomputed completions.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0; m_data <= 8'h00; m_ferr <= 1'b0; m_ovr <= 1'b0; m_busy <= 1'b0;
    end else begin
      m_ferr <= cur_done_err;
      m_ovr  <= 1'b0;
      if (cur_done_ok) begin
        if (!m_valid || rx_ready) begin
          m_data  <= cur_data;
          m_valid <= 1'b1;
        end else begin
          m_ovr <= 1'b1;
        end
      end else if (m_valid && rx_ready) begin
        m_valid <= 1'b0;
      end
      if (cur_bon) m_busy <= 1'b1;
      else if (cur_boff) m_busy <= 1'b0;
    end
  end

  // Per-cycle comparison of DUT outputs against the reference.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rx_valid", {31'd0, rx_valid}, {31'd0, m_valid});
      check("rx_data", {24'd0, rx_data}, {24'd0, m_data});
      check("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
      check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      if (frame_err) ferr_seen <= ferr_seen + 1;
      if (overrun) ovr_seen <= ovr_seen + 1;
      if (rx_valid && !prev_valid) rise_cyc <= cyc;
      prev_valid <= rx_valid;
    end
  end

  task automatic clear_flags();
    cur_done_ok = 1'b0; cur_done_err = 1'b0; cur_bon = 1'b0; cur_boff = 1'b0; cur_data = 8'h00;
  endtask

  task automatic gen_idle(input int n);
    repeat (n) line_q.push_back(1'b1);
  endtask

  // Frame starting at the current tick; the stop bit is sampled at tick
  // start + 8 + 16*(DATA_W+1).
  task automatic gen_frame(input logic [7:0] d, input int stop_len, input bit bad, input int low_extra);
    int t0;
    int e;
    t0 = line_q.size();
    e  = t0 + 8 + 16 * (DATA_W + 1);
    bon[t0] = 1'b1;
    repeat (16) line_q.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) repeat (16) line_q.push_back(d[i]);
    done_data[e] = d;
    if (!bad) begin
      repeat (stop_len) line_q.push_back(1'b1);
      done_kind[e] = 1;
      boff[e] = 1'b1;
    end else begin
      repeat (16 + low_extra) line_q.push_back(1'b0);
      done_kind[e] = 2;
      boff[line_q.size()] = 1'b1;
      line_q.push_back(1'b1);
    end
  endtask

  // Short low pulse: busy from detection until the centre re-check.
  task automatic gen_glitch(input int g);
    int t0;
    t0 = line_q.size();
    bon[t0] = 1'b1;
    boff[t0 + 8] = 1'b1;
    repeat (g) line_q.push_back(1'b0);
    repeat (10) line_q.push_back(1'b1);
  endtask

  task automatic run_ticks();
    while (cur_t < line_q.size()) begin
      for (int c = 0; c < cpt; c++) begin
        @(negedge clk);
        serial_in  = line_q[cur_t];
        stb_sample = (c == cpt - 1);
        clear_flags();
        if (stb_sample) begin
          if (done_kind.exists(cur_t)) begin
            cur_done_ok  = (done_kind[cur_t] == 1);
            cur_done_err = (done_kind[cur_t] == 2);
            cur_data     = done_data[cur_t];
            if (cur_done_ok) done_cyc = cyc;
          end
          cur_bon  = bon.exists(cur_t);
          cur_boff = boff.exists(cur_t);
        end
        case (ready_mode)
          0:       rx_ready = 1'($urandom_range(0, 1));
          1:       rx_ready = ready_val;
          default: rx_ready = cur_done_ok;
        endcase
      end
      cur_t++;
    end
    @(negedge clk);
    stb_sample = 1'b0;
    clear_flags();
    rx_ready = 1'b0;
  endtask

  task automatic pulse_ready();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  int f0, o0;

  initial begin
    rst = 1'b1; stb_sample = 1'b0; serial_in = 1'b1; rx_ready = 1'b0;
    clear_flags();
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // 0xA5 at 16 clocks per tick.
    cpt = 16; ready_mode = 1; ready_val = 1'b0;
    f0 = ferr_seen;
    gen_idle(3); gen_frame(8'hA5, 16, 1'b0, 0); gen_idle(2);
    run_ticks();
    check("a5_data", {24'd0, rx_data}, 32'h0000_00A5);
    check("a5_valid", {31'd0, rx_valid}, 32'd1);
    check("a5_latency", rise_cyc - done_cyc, 32'd1);
    check("a5_ferr", ferr_seen - f0, 32'd0);
    pulse_ready();
    check("a5_consumed", {31'd0, rx_valid}, 32'd0);

    // Four-tick glitch.
    cpt = 4;
    f0 = ferr_seen; o0 = ovr_seen;
    gen_idle(2); gen_glitch(4); gen_idle(5);
    run_ticks();
    check("glitch_valid", {31'd0, rx_valid}, 32'd0);
    check("glitch_ferr", ferr_seen - f0, 32'd0);
    check("glitch_ovr", ovr_seen - o0, 32'd0);
    check("glitch_busy", {31'd0, busy}, 32'd0);

    // Bad stop bit, line low 20 bit times, then 0x55.
    f0 = ferr_seen;
    gen_frame(8'h3C, 16, 1'b1, 20 * 16 - 16); gen_idle(3);
    run_ticks();
    check("break_ferr", ferr_seen - f0, 32'd1);
    check("break_valid", {31'd0, rx_valid}, 32'd0);
    gen_frame(8'h55, 16, 1'b0, 0); gen_idle(2);
    run_ticks();
    check("after_break_data", {24'd0, rx_data}, 32'h0000_0055);
    pulse_ready();

    // Back-to-back 0x11, 0x22 without consumption.
    o0 = ovr_seen;
    gen_frame(8'h11, 16, 1'b0, 0); gen_frame(8'h22, 16, 1'b0, 0); gen_idle(2);
    run_ticks();
    check("ovr_data", {24'd0, rx_data}, 32'h0000_0011);
    check("ovr_count", ovr_seen - o0, 32'd1);
    pulse_ready();
    check("ovr_consumed", {31'd0, rx_valid}, 32'd0);

    // Ready exactly in the completion cycle of the second byte.
    ready_mode = 2; o0 = ovr_seen;
    gen_frame(8'h33, 16, 1'b0, 0); gen_frame(8'h22, 9, 1'b0, 0); gen_idle(2);
    run_ticks();
    check("same_cycle_data", {24'd0, rx_data}, 32'h0000_0022);
    check("same_cycle_valid", {31'd0, rx_valid}, 32'd1);
    check("same_cycle_ovr", ovr_seen - o0, 32'd0);
    pulse_ready();

    // Reset in the middle of bit 4 of 0xFF, then 0x0F.
    ready_mode = 1; ready_val = 1'b0;
    f0 = ferr_seen; o0 = ovr_seen;
    bon[line_q.size()] = 1'b1;
    repeat (16) line_q.push_back(1'b0);
    repeat (4 * 16 + 8) line_q.push_back(1'b1);
    run_ticks();
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    gen_idle(3); gen_frame(8'h0F, 16, 1'b0, 0); gen_idle(2);
    run_ticks();
    check("rst_mid_data", {24'd0, rx_data}, 32'h0000_000F);
    check("rst_mid_ferr", ferr_seen - f0, 32'd0);
    check("rst_mid_ovr", ovr_seen - o0, 32'd0);
    pulse_ready();

    // Randomized traffic with random consumer readiness.
    ready_mode = 0;
    for (int n = 0; n < 30; n++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k == 0) begin
        gen_glitch($urandom_range(1, 7));
      end else if (k == 1) begin
        gen_frame(8'($urandom), 16, 1'b1, $urandom_range(0, 40));
        gen_idle($urandom_range(0, 3));
      end else begin
        gen_frame(8'($urandom), $urandom_range(9, 16), 1'b0, 0);
        gen_idle($urandom_range(0, 3));
      end
    end
    gen_idle(4);
    run_ticks();
    ready_mode = 1; ready_val = 1'b1;
    gen_idle(3);
    run_ticks();
    check("drain_valid", {31'd0, rx_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
